uart_rx: RTL and testbench

// - Serial 8N1 UART receiver with a small show-ahead receive FIFO; upstream of the MMU.
// - Counterpart of uart_tx. Feeds received bytes to the core through MMU read ports
//   (UART_RX data / status).
// - Samples the FPGA rx pin mid-bit, validates start and stop bits, and buffers bytes
//   so that back-to-back frames are not lost while the core polls.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, default bit timing and
// the MMU address map / status word layout seen by the core.
package uart_rx_pkg;

    localparam int unsigned DefaultClksPerBit = 434;

    localparam logic [31:0] UartRxDataAddr   = 32'h0000_4008;
    localparam logic [31:0] UartRxStatusAddr = 32'h0000_400C;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxStart = 2'd1,
        RxData  = 2'd2,
        RxStop  = 2'd3
    } rx_state_e;

    // Status word as read from UartRxStatusAddr, bits [3:0].
    function automatic logic [31:0] rx_status_word(input logic frame_err,
                                                   input logic overrun,
                                                   input logic full,
                                                   input logic valid);
        return {28'd0, frame_err, overrun, full, valid};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers; head word is driven to zero when
// empty. Pops while empty and pushes while full (without a pop) are ignored.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             pop_en;
    logic             push_en;

    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                  (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        pop_en  = pop_i && !empty_o;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push_en = push_i && (!full_o || pop_en);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: pin synchronizer, mid-bit sampling FSM, sticky error flags and a
// show-ahead receive FIFO polled by the MMU.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned ClksPerBit = DefaultClksPerBit,
    parameter int unsigned FifoDepth  = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       read_en_i,
    input  logic       clear_err_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_full_o,
    output logic       overrun_o,
    output logic       frame_err_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta_q, rx_s_q, prev_q;
    logic [1:0]      fill_q;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic            start_det;
    logic            stop_ok;
    logic            stop_bad;
    logic            fifo_empty;
    logic            fifo_full;
    logic            overrun_set;

    // fill_q keeps prev_q at 0 until rx_s_q holds a real pin sample, so the reset value
    // of the synchronizer can never fake a falling edge on a line held low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            prev_q    <= 1'b0;
            fill_q    <= 2'b00;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            prev_q    <= fill_q[1] & rx_s_q;
            fill_q    <= {fill_q[0], 1'b1};
        end
    end

    assign start_det = prev_q && !rx_s_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;

        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (start_det) begin
                    state_d = RxStart;
                end
            end
            RxStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_s_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                // Leaving at mid stop bit lets the next start edge follow without a gap.
                if (cnt_q == CntFull) begin
                    cnt_d    = '0;
                    stop_ok  = rx_s_q;
                    stop_bad = !rx_s_q;
                    state_d  = RxIdle;
                end
            end
            default: begin
                state_d = RxIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    sync_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (stop_ok),
        .pop_i   (read_en_i),
        .din_i   (shift_q),
        .dout_o  (rx_data_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // A full FIFO is never empty, so a read_en here is always a real pop.
    assign overrun_set = stop_ok && fifo_full && !read_en_i;

    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (clear_err_i) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
        if (stop_bad) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_valid_o  = !fifo_empty;
    assign rx_full_o   = fifo_full;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bit-banged 8N1 line model drives rx, and each
// observation is checked against hand-computed values.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned Cpb   = 16;
    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       read_en;
    logic       clear_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic       overrun;
    logic       frame_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned frame_start_cyc = 0;
    int unsigned rise_cyc = 0;
    logic        valid_prev = 1'b0;

    uart_rx #(
        .ClksPerBit (Cpb),
        .FifoDepth  (Depth)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .read_en_i   (read_en),
        .clear_err_i (clear_err),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_full_o   (rx_full),
        .overrun_o   (overrun),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rx_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge with the line idle high.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        frame_start_cyc = cyc;
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (Cpb) @(negedge clk);
        end
        rx = stop_bit;
        repeat (Cpb) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, rx_data}, {24'd0, exp});
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rx        = 1'b1;
        read_en   = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_full", {31'd0, rx_full}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Good frame 0x55; byte appears on edge 155 counted from the start-bit drive.
        send_frame(8'h55, 1'b1);
        check("byte55_valid", {31'd0, rx_valid}, 32'd1);
        check("byte55_data", {24'd0, rx_data}, 32'h55);
        check("byte55_latency", rise_cyc - frame_start_cyc, 32'd155);
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        check("after_pop_valid", {31'd0, rx_valid}, 32'd0);
        check("after_pop_data", {24'd0, rx_data}, 32'h00);
        repeat (5) @(negedge clk);

        // Short low glitch: START entered, then rejected at the mid-bit sample.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_in_start", {30'd0, dut.state_q}, {30'd0, RxStart});
        repeat (3) @(negedge clk);
        check("glitch_back_idle", {30'd0, dut.state_q}, {30'd0, RxIdle});
        repeat (20) @(negedge clk);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);
        check("glitch_flags", {30'd0, overrun, frame_err}, 32'd0);

        // Bad stop bit.
        send_frame(8'hA3, 1'b0);
        repeat (5) @(negedge clk);
        check("frame_err_set", {31'd0, frame_err}, 32'd1);
        check("frame_err_valid", {31'd0, rx_valid}, 32'd0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("frame_err_cleared", {31'd0, frame_err}, 32'd0);
        repeat (5) @(negedge clk);

        // Five back-to-back frames into a 4-deep FIFO.
        for (int b = 1; b <= 4; b++) begin
            send_frame(8'(b), 1'b1);
        end
        check("fill_full", {31'd0, rx_full}, 32'd1);
        check("fill_no_overrun", {31'd0, overrun}, 32'd0);
        send_frame(8'h05, 1'b1);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("overrun_frame_err", {31'd0, frame_err}, 32'd0);
        pop_check("ovr_read0", 8'h01);
        pop_check("ovr_read1", 8'h02);
        pop_check("ovr_read2", 8'h03);
        pop_check("ovr_read3", 8'h04);
        check("ovr_drained", {31'd0, rx_valid}, 32'd0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("overrun_cleared", {31'd0, overrun}, 32'd0);
        repeat (5) @(negedge clk);

        // Full FIFO, pop coincident with the push of 0x14.
        for (int b = 0; b < 4; b++) begin
            send_frame(8'h10 + 8'(b), 1'b1);
        end
        check("full2_full", {31'd0, rx_full}, 32'd1);
        fork
            send_frame(8'h14, 1'b1);
            begin
                repeat (154) @(negedge clk);
                read_en = 1'b1;
                @(negedge clk);
                read_en = 1'b0;
            end
        join
        check("simul_no_overrun", {31'd0, overrun}, 32'd0);
        check("simul_still_full", {31'd0, rx_full}, 32'd1);
        pop_check("simul_read0", 8'h11);
        pop_check("simul_read1", 8'h12);
        pop_check("simul_read2", 8'h13);
        pop_check("simul_read3", 8'h14);
        check("simul_drained", {31'd0, rx_valid}, 32'd0);
        repeat (5) @(negedge clk);

        // Reset during bit 0 of 0x7E (line low), released with the line still low.
        rx = 1'b0;
        repeat (Cpb + 8) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_mid_state", {30'd0, dut.state_q}, {30'd0, RxIdle});
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_flags", {30'd0, overrun, frame_err}, 32'd0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 1'b1);
        check("post_rst_valid", {31'd0, rx_valid}, 32'd1);
        check("post_rst_data", {24'd0, rx_data}, 32'h3C);
        check("post_rst_flags", {30'd0, overrun, frame_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
